// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    function automatic int clks_per_baud(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Write-side and status signals of the UART transmitter.
interface uart_tx_if #(
    parameter int FIFO_DEPTH = 8
);
    logic                                en;
    logic                                wr_en;
    logic [7:0]                          wr_data;
    logic                                full;
    logic                                empty;
    logic [$clog2(FIFO_DEPTH+1)-1:0]     count;
    logic                                overflow;
    logic                                busy;
    logic                                tx;

    modport master (
        output en, wr_en, wr_data,
        input  full, empty, count, overflow, busy, tx
    );

    modport slave (
        input  en, wr_en, wr_data,
        output full, empty, count, overflow, busy, tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered full/empty/count and an overflow pulse.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + CW'(1);
        else if (do_pop && !do_push)
            count_nxt = count - CW'(1);
    end

    // Pointers wrap naturally; count alone tells full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count    <= count_nxt;
            full     <= (count_nxt == CW'(DEPTH));
            empty    <= (count_nxt == '0);
            overflow <= push && full;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: queues bytes in a FIFO and shifts them out LSB first.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);
    localparam int CPB = clks_per_baud(CLK_FREQ, BAUD);
    localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;

    if (CPB < 2) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end

    tx_state_t     state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    head;
    logic          tx_q;
    logic          busy_q;
    logic          fifo_empty;
    logic          baud_done;
    logic          pop;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.wr_en),
        .pop      (pop),
        .din      (bus.wr_data),
        .dout     (head),
        .full     (bus.full),
        .empty    (fifo_empty),
        .overflow (bus.overflow),
        .count    (bus.count)
    );

    assign bus.empty = fifo_empty;
    assign bus.tx    = tx_q;
    assign bus.busy  = busy_q;

    assign baud_done = (baud_cnt == BW'(CPB - 1));
    // A new frame may start from IDLE or straight out of a finished stop bit.
    assign pop = bus.en && !fifo_empty &&
                 (state == IDLE || (state == STOP && baud_done));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            baud_cnt <= (state == IDLE || baud_done) ? '0 : baud_cnt + BW'(1);
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift  <= head;
                        tx_q   <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= START;
                    end
                end
                START: if (baud_done) begin
                    tx_q    <= shift[0];
                    bit_idx <= '0;
                    state   <= DATA;
                end
                DATA: if (baud_done) begin
                    if (bit_idx == 3'd7) begin
                        tx_q  <= 1'b1;
                        state <= STOP;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        tx_q    <= shift[bit_idx + 3'd1];
                    end
                end
                STOP: if (baud_done) begin
                    if (pop) begin
                        shift <= head;
                        tx_q  <= 1'b0;
                        state <= START;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: scoreboard of queued bytes checked by a line monitor.
module tb_uart_tx;
    localparam int CLK_FREQ = 10_000_000;
    localparam int BAUD     = 115200;
    localparam int DEPTH    = 8;
    localparam int CPB      = 86;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus();

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    bit         mon_busy = 1'b0;
    logic [7:0] sb[$];
    int         starts[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon_wait(input int n, inout bit abort);
        repeat (n) begin
            @(negedge clk);
            if (rst) abort = 1'b1;
        end
    endtask

    // Line monitor: samples mid-bit and compares against the scoreboard.
    initial begin : monitor
        logic       prev;
        logic [7:0] data;
        logic [7:0] exp;
        logic       stop;
        bit         abort;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && !bus.tx) begin
                mon_busy = 1'b1;
                abort    = 1'b0;
                starts.push_back(cyc);
                mon_wait(CPB / 2, abort);
                if (!abort) check("mon_start_bit", bus.tx, 0);
                for (int i = 0; i < 8; i++) begin
                    mon_wait(CPB, abort);
                    data[i] = bus.tx;
                end
                mon_wait(CPB, abort);
                stop = bus.tx;
                if (!abort) begin
                    check("mon_stop_bit", stop, 1);
                    check("mon_sb_nonempty", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        exp = sb.pop_front();
                        check("mon_data", data, exp);
                    end
                end
                mon_busy = 1'b0;
            end
            prev = bus.tx;
        end
    end

    task automatic write_byte(input logic [7:0] d, input bit sent);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        if (sent) sb.push_back(d);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || mon_busy || bus.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < budget, 1);
    endtask

    initial begin : stim
        int         lows;
        logic [7:0] d;
        logic       e;
        logic       first;
        logic       last;
        bus.en      = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;

        // Reset state
        repeat (2) begin
            @(negedge clk);
            check("rst_tx", bus.tx, 1);
            check("rst_busy", bus.busy, 0);
            check("rst_empty", bus.empty, 1);
            check("rst_count", bus.count, 0);
        end
        check("rst_full", bus.full, 0);
        check("rst_overflow", bus.overflow, 0);
        rst    = 1'b0;
        bus.en = 1'b1;
        lows   = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!bus.tx) lows++;
        end
        check("idle_quiet", lows, 0);

        // Single byte 0x55: alternating line, every segment exactly CPB cycles
        d = 8'h55;
        write_byte(d, 1);
        check("lat_before", bus.tx, 1);
        @(negedge clk);
        check("lat_fall", bus.tx, 0);
        check("busy_on", bus.busy, 1);
        for (int s = 0; s < 10; s++) begin
            if (s == 0)      e = 1'b0;
            else if (s == 9) e = 1'b1;
            else             e = d[s-1];
            first = bus.tx;
            repeat (CPB - 1) @(negedge clk);
            last = bus.tx;
            check("seg_first", first, e);
            check("seg_last", last, e);
            if (s == 9) check("busy_last", bus.busy, 1);
            @(negedge clk);
        end
        check("busy_off", bus.busy, 0);
        check("tx_idle", bus.tx, 1);
        wait_drain(200, "drain_55");

        // Back-to-back 'H','i'
        starts.delete();
        write_byte(8'h48, 1);
        write_byte(8'h69, 1);
        check("b2b_fall", bus.tx, 0);
        check("b2b_count1", bus.count, 1);
        repeat (10 * CPB - 1) @(negedge clk);
        check("b2b_pre_tx", bus.tx, 1);
        check("b2b_pre_count", bus.count, 1);
        @(negedge clk);
        check("b2b_second_fall", bus.tx, 0);
        check("b2b_count0", bus.count, 0);
        check("b2b_busy", bus.busy, 1);
        wait_drain(2000, "drain_b2b");
        check("b2b_starts", starts.size(), 2);
        if (starts.size() >= 2) check("b2b_spacing", starts[1] - starts[0], 10 * CPB);

        // Fill and overflow with the transmitter disabled
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                check("fill_full", bus.full, (i >= 8) ? 1 : 0);
                check("fill_overflow", bus.overflow, (i >= 9) ? 1 : 0);
            end
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(i);
            if (i < 8) sb.push_back(8'(i));
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        check("fill_full_end", bus.full, 1);
        check("fill_overflow_10", bus.overflow, 1);
        check("fill_count", bus.count, 8);
        check("fill_tx_idle", bus.tx, 1);
        @(negedge clk);
        check("fill_overflow_clear", bus.overflow, 0);
        check("fill_count_hold", bus.count, 8);
        bus.en = 1'b1;
        wait_drain(8000, "drain_fill");
        check("fill_empty", bus.empty, 1);
        check("fill_count0", bus.count, 0);

        // Enable dropped during bit 3 with two bytes queued
        starts.delete();
        write_byte(8'hA1, 1);
        write_byte(8'h3C, 1);
        check("en_fall", bus.tx, 0);
        repeat (4 * CPB + 20) @(negedge clk);
        bus.en = 1'b0;
        repeat (10 * CPB - (4 * CPB + 20)) @(negedge clk);
        check("en_frame_done_busy", bus.busy, 0);
        check("en_frame_done_tx", bus.tx, 1);
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (!bus.tx) lows++;
        end
        check("en_hold_quiet", lows, 0);
        check("en_hold_count", bus.count, 1);
        bus.en = 1'b1;
        @(negedge clk);
        check("en_restart_fall", bus.tx, 0);
        wait_drain(2000, "drain_en");
        check("en_starts", starts.size(), 2);

        // Reset during bit 4 with three bytes queued
        write_byte(8'h0F, 1);
        write_byte(8'h2E, 1);
        write_byte(8'hC3, 1);
        repeat (5 * CPB + 20 - 1) @(negedge clk);
        check("mid_bit4_low", bus.tx, 0);
        check("mid_count", bus.count, 2);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", bus.tx, 1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_count", bus.count, 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_count", bus.count, 0);
        check("post_rst_empty", bus.empty, 1);
        starts.delete();
        lows = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!bus.tx) lows++;
        end
        check("post_rst_quiet", lows, 0);
        check("post_rst_starts", starts.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
